// File: rtl/cdic_pkg.sv
// cdic_pkg: shared constants for the CDIC host interface.
//   - Register byte offsets within the 16 KB host window.
//   - RAM_LIMIT: first byte offset past the buffer RAM.
//   - Register-bank indices and the offset-to-index decoder.
package cdic_pkg;

   localparam logic [13:0] CDIC_COMMAND    = 14'h3C00;
   localparam logic [13:0] CDIC_TIME_HI    = 14'h3C02;
   localparam logic [13:0] CDIC_TIME_LO    = 14'h3C04;
   localparam logic [13:0] CDIC_FILE       = 14'h3C06;
   localparam logic [13:0] CDIC_CHANNEL_HI = 14'h3C08;
   localparam logic [13:0] CDIC_CHANNEL_LO = 14'h3C0A;
   localparam logic [13:0] CDIC_ACHANNEL   = 14'h3C0C;
   localparam logic [13:0] CDIC_ABUF       = 14'h3FF4;
   localparam logic [13:0] CDIC_XBUF       = 14'h3FF6;
   localparam logic [13:0] CDIC_DMACTL     = 14'h3FF8;
   localparam logic [13:0] CDIC_AUDCTL     = 14'h3FFA;
   localparam logic [13:0] CDIC_IVEC       = 14'h3FFC;
   localparam logic [13:0] CDIC_DBUF       = 14'h3FFE;

   localparam logic [13:0] RAM_LIMIT       = 14'h3C00;
   localparam logic [15:0] CDIC_IVEC_RESET = 16'h000F;

   // Register-bank slot numbers; REG_NONE marks an unmapped offset.
   localparam int unsigned NUM_REGS = 13;
   localparam logic [3:0]  IDX_ABUF = 4'd7;
   localparam logic [3:0]  IDX_XBUF = 4'd8;
   localparam logic [3:0]  IDX_IVEC = 4'd11;
   localparam logic [3:0]  REG_NONE = 4'd13;

   function automatic logic [3:0] reg_idx(input logic [13:0] off);
      case (off)
         CDIC_COMMAND:    return 4'd0;
         CDIC_TIME_HI:    return 4'd1;
         CDIC_TIME_LO:    return 4'd2;
         CDIC_FILE:       return 4'd3;
         CDIC_CHANNEL_HI: return 4'd4;
         CDIC_CHANNEL_LO: return 4'd5;
         CDIC_ACHANNEL:   return 4'd6;
         CDIC_ABUF:       return IDX_ABUF;
         CDIC_XBUF:       return IDX_XBUF;
         CDIC_DMACTL:     return 4'd9;
         CDIC_AUDCTL:     return 4'd10;
         CDIC_IVEC:       return IDX_IVEC;
         CDIC_DBUF:       return 4'd12;
         default:         return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cdic_buffer_ram.sv
// cdic_buffer_ram: single-port 8K x 16 buffer RAM, two byte enables, registered read.
// Ports:
//   clk30   in   clock
//   addr    in   word address
//   we      in   write enable
//   be      in   byte enables {upper, lower}
//   wdata   in   write data
//   rdata   out  read data, one cycle after addr
// Contents are not reset so the array maps onto block RAM.
module cdic_buffer_ram #(
   parameter int unsigned ADDR_W = 13
) (
   input  logic              clk30,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [1:0]        be,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata
);

   logic [15:0] mem_q [2**ADDR_W];
   logic [15:0] rdata_q;

   always_ff @(posedge clk30) begin
      if (we && be[1]) mem_q[addr][15:8] <= wdata[15:8];
      if (we && be[0]) mem_q[addr][7:0]  <= wdata[7:0];
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/cdic_host_if.sv
// cdic_host_if: CPU-side host interface of the CD interface controller.
// Buffer RAM below RAM_WORDS words, control/status registers above it, 16 KB aliasing.
// Ports:
//   clk30         in   system clock
//   reset         in   synchronous active-high reset
//   address[23:1] in   CPU word address, only [13:1] decoded
//   din           in   CPU write data
//   dout          out  read data, zero unless bus_ack on a read
//   uds, lds      in   upper/lower byte strobes
//   write_strobe  in   1 = write, 0 = read
//   cs            in   block select from the external decoder
//   bus_ack       out  cycle completion (DTACK equivalent)
// Build option: define CDIC_TRACE_EN for a simulation-only trace of register accesses.
module cdic_host_if
   import cdic_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 7680,
   parameter logic [15:0] IVEC_RESET = CDIC_IVEC_RESET
) (
   input  logic        clk30,
   input  logic        reset,
   input  logic [23:1] address,
   input  logic [15:0] din,
   output logic [15:0] dout,
   input  logic        uds,
   input  logic        lds,
   input  logic        write_strobe,
   input  logic        cs,
   output logic        bus_ack
);

   logic [12:0] word_addr;
   logic [13:0] off;
   logic        access, wr, rd, rd_ack, is_ram;
   logic [3:0]  ridx;
   logic [15:0] reg_rdata, ram_rdata;

   logic [15:0] regs_q [NUM_REGS];
   logic [15:0] regs_d [NUM_REGS];
   logic        ack_q, ack_d;
   logic [15:0] dout_q, dout_d;
   logic        sel_ram_q, sel_ram_d;

   // Upper address bits are deliberately ignored: the window aliases every 16 KB.
   logic unused_addr;
   assign unused_addr = ^address[23:14];

   always_comb begin
      word_addr = address[13:1];
      off       = {word_addr, 1'b0};
      access    = cs && (uds || lds);
      wr        = access && write_strobe;
      rd        = access && !write_strobe;
      rd_ack    = rd && ack_q;
      is_ram    = 32'(word_addr) < RAM_WORDS;
      ridx      = is_ram ? REG_NONE : reg_idx(off);
      reg_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ridx == 4'(i)) reg_rdata = regs_q[i];
      end
   end

   cdic_buffer_ram #(
      .ADDR_W (13)
   ) u_ram (
      .clk30 (clk30),
      .addr  (word_addr),
      .we    (wr && is_ram),
      .be    ({uds, lds}),
      .wdata (din),
      .rdata (ram_rdata)
   );

   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         // Read-to-clear of the buffer-full flags on the acked read cycle.
         if (rd_ack && ridx == 4'(i) && (ridx == IDX_ABUF || ridx == IDX_XBUF)) begin
            regs_d[i][15] = 1'b0;
         end
         // Applied after the clear so a write in the same cycle wins.
         if (wr && ridx == 4'(i)) begin
            if (uds) regs_d[i][15:8] = din[15:8];
            if (lds) regs_d[i][7:0]  = din[7:0];
         end
      end

      // Toggle gives one wait state and an ack every second cycle while held.
      ack_d     = rd && !ack_q;
      dout_d    = dout_q;
      sel_ram_d = sel_ram_q;
      if (rd && !ack_q) begin
         dout_d    = reg_rdata;
         sel_ram_d = is_ram;
      end
   end

   always_ff @(posedge clk30) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (4'(i) == IDX_IVEC) ? IVEC_RESET : 16'h0000;
         end
         ack_q     <= 1'b0;
         dout_q    <= 16'h0000;
         sel_ram_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         ack_q     <= ack_d;
         dout_q    <= dout_d;
         sel_ram_q <= sel_ram_d;
      end
   end

   // RAM data comes straight from the RAM output register, which aligns with dout_q.
   assign bus_ack = wr || rd_ack;
   assign dout    = rd_ack ? (sel_ram_q ? ram_rdata : dout_q) : 16'h0000;

`ifdef CDIC_TRACE_EN
   always @(posedge clk30) begin
      if (!reset && bus_ack && !is_ram) begin
         $display("CDIC %s %04h %04h %0d %0d", write_strobe ? "W" : "R", off,
                  write_strobe ? din : dout, uds, lds);
      end
   end
`else
`endif

endmodule

// File: tb/tb_cdic_host_if.sv
module tb_cdic_host_if;

   logic        clk30 = 1'b0;
   logic        reset = 1'b1;
   logic [23:1] address = '0;
   logic [15:0] din = '0;
   logic [15:0] dout;
   logic        uds = 1'b0;
   logic        lds = 1'b0;
   logic        write_strobe = 1'b0;
   logic        cs = 1'b0;
   logic        bus_ack;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          is_rd;
      logic [15:0] data;
      string       name;
   } exp_t;

   exp_t sb[$];

   cdic_host_if dut (
      .clk30        (clk30),
      .reset        (reset),
      .address      (address),
      .din          (din),
      .dout         (dout),
      .uds          (uds),
      .lds          (lds),
      .write_strobe (write_strobe),
      .cs           (cs),
      .bus_ack      (bus_ack)
   );

   always #5 clk30 = ~clk30;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every ack pops one expected response; reads compare dout.
   always @(negedge clk30) begin
      if (!reset && bus_ack) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack at %0t, expected none", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.is_rd) check(e.name, dout, e.data);
         end
      end else if (!reset && cs) begin
         check("dout_idle_zero", dout, 16'h0000);
      end
   end

   task automatic release_bus();
      cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
   endtask

   // All tasks start and end at posedge + 1.
   task automatic do_write(input logic [23:0] ba, input logic [15:0] d, input logic u,
                           input logic l, input string name);
      address = ba[23:1]; din = d; uds = u; lds = l; write_strobe = 1'b1; cs = 1'b1;
      sb.push_back('{1'b0, 16'h0000, name});
      @(negedge clk30);
      check({name, "_ack"}, 16'(bus_ack), 16'h0001);
      @(posedge clk30); #1;
      release_bus();
   endtask

   task automatic do_read(input logic [23:0] ba, input logic [15:0] exp, input string name);
      address = ba[23:1]; uds = 1'b1; lds = 1'b1; write_strobe = 1'b0; cs = 1'b1;
      sb.push_back('{1'b1, exp, name});
      @(negedge clk30);
      check({name, "_wait"}, 16'(bus_ack), 16'h0000);
      @(posedge clk30);
      @(negedge clk30);
      check({name, "_ack"}, 16'(bus_ack), 16'h0001);
      @(posedge clk30); #1;
      release_bus();
   endtask

   typedef struct {
      logic [23:0] ba;
      string       name;
   } reg_t;

   reg_t zero_regs[12] = '{
      '{24'h303C00, "rst_command"}, '{24'h303C02, "rst_time_hi"},
      '{24'h303C04, "rst_time_lo"}, '{24'h303C06, "rst_file"},
      '{24'h303C08, "rst_chan_hi"}, '{24'h303C0A, "rst_chan_lo"},
      '{24'h303C0C, "rst_achannel"}, '{24'h303FF4, "rst_abuf"},
      '{24'h303FF6, "rst_xbuf"}, '{24'h303FF8, "rst_dmactl"},
      '{24'h303FFA, "rst_audctl"}, '{24'h303FFE, "rst_dbuf"}
   };

   initial begin
      repeat (3) @(posedge clk30);
      #1 reset = 1'b0;

      // Reset values.
      do_read(24'h303FFC, 16'h000F, "rst_ivec");
      for (int i = 0; i < 12; i++) do_read(zero_regs[i].ba, 16'h0000, zero_regs[i].name);

      // Buffer RAM with byte lanes.
      do_write(24'h300100, 16'hA55A, 1'b1, 1'b1, "ram_wr_word");
      do_read(24'h300100, 16'hA55A, "ram_rd_word");
      do_write(24'h300100, 16'h1200, 1'b1, 1'b0, "ram_wr_upper");
      do_read(24'h300100, 16'h125A, "ram_rd_upper");

      // COMMAND and its 16 KB alias.
      do_write(24'h303C00, 16'h0023, 1'b1, 1'b1, "cmd_wr");
      do_read(24'h303C00, 16'h0023, "cmd_rd");
      do_read(24'h307C00, 16'h0023, "cmd_rd_alias");

      // Read-to-clear flags.
      do_write(24'h303FF6, 16'h8001, 1'b1, 1'b1, "xbuf_wr");
      do_read(24'h303FF6, 16'h8001, "xbuf_rd1");
      do_read(24'h303FF6, 16'h0001, "xbuf_rd2");
      do_write(24'h303FF4, 16'h80FF, 1'b0, 1'b1, "abuf_wr_lower");
      do_read(24'h303FF4, 16'h00FF, "abuf_rd_lower");
      do_write(24'h303FF4, 16'h8000, 1'b1, 1'b0, "abuf_wr_upper");
      do_read(24'h303FF4, 16'h80FF, "abuf_rd1");
      do_read(24'h303FF4, 16'h00FF, "abuf_rd2");

      // Unmapped register-space offset.
      do_read(24'h303E00, 16'h0000, "unmapped_rd");
      do_write(24'h303E00, 16'hBEEF, 1'b1, 1'b1, "unmapped_wr");
      do_read(24'h303E00, 16'h0000, "unmapped_rd2");
      do_read(24'h303C00, 16'h0023, "cmd_after_unmapped");

      // Reset in cycle 1 of a read: no ack in the following cycle.
      address = 23'h303C00 >> 1; uds = 1'b1; lds = 1'b1; write_strobe = 1'b0; cs = 1'b1;
      @(negedge clk30);
      check("rst_mid_cyc1", 16'(bus_ack), 16'h0000);
      reset = 1'b1;
      @(posedge clk30); #1;
      reset = 1'b0;
      @(negedge clk30);
      check("rst_mid_no_ack", 16'(bus_ack), 16'h0000);
      @(posedge clk30); #1;
      release_bus();
      @(posedge clk30); #1;
      do_read(24'h303C00, 16'h0000, "cmd_after_reset");
      do_read(24'h303FFC, 16'h000F, "ivec_after_reset");

      // Strobes both low is not an access.
      address = 23'h300100 >> 1; din = 16'hFFFF; uds = 1'b0; lds = 1'b0;
      write_strobe = 1'b1; cs = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk30);
         check("no_strobe_no_ack", 16'(bus_ack), 16'h0000);
         @(posedge clk30); #1;
      end
      release_bus();
      do_read(24'h300100, 16'h125A, "ram_unchanged");

      repeat (2) @(posedge clk30);
      check("scoreboard_empty", 16'(sb.size()), 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
